// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, BOOT/RUN sequencing and the IF/ID pipeline register.
// Redirect outranks stall for both PC and IF/ID; flush and redirect turn IF/ID into a bubble.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    localparam int unsigned XLEN = 32;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   if_id_pc_q, if_id_pc_d;
    logic [XLEN-1:0]   if_id_pc4_q, if_id_pc4_d;
    logic [XLEN-1:0]   if_id_instr_q, if_id_instr_d;
    logic              if_id_valid_q, if_id_valid_d;
    logic              misalign_q, misalign_d;
    logic [XLEN-1:0]   fetch_count_q, fetch_count_d;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: BOOT lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        if (state_q == BOOT) begin
            state_d = RUN;
        end
    end

    // Datapath next values; IF/ID always captures the current PC except on hold
    always_comb begin
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        misalign_d    = 1'b0;
        fetch_count_d = fetch_count_q;

        if (state_q == BOOT) begin
            pc_d          = RESET_PC;
            if_id_pc_d    = pc_q;
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end else begin
            if (redirect) begin
                pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
                misalign_d = (redirect_pc[1:0] != 2'b00);
            end else if (!stall) begin
                pc_d = pc_q + XLEN'(4);
            end

            if (flush || redirect) begin
                if_id_pc_d    = pc_q;
                if_id_instr_d = NOP_INSTR;
                if_id_valid_d = 1'b0;
            end else if (!stall) begin
                if_id_pc_d    = pc_q;
                if_id_instr_d = imem_rdata;
                if_id_valid_d = 1'b1;
                fetch_count_d = fetch_count_q + XLEN'(1);
            end
        end

        if_id_pc4_d = if_id_pc_d + XLEN'(4);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            if_id_pc_q    <= RESET_PC;
            if_id_pc4_q   <= RESET_PC + XLEN'(4);
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            misalign_q    <= misalign_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr    = pc_q;
    assign if_id_pc     = if_id_pc_q;
    assign if_id_pc4    = if_id_pc4_q;
    assign if_id_instr  = if_id_instr_q;
    assign if_id_valid  = if_id_valid_q;
    assign misalign_err = misalign_q;
    assign fetch_count  = fetch_count_q;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter: NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; sampled on the rising clk edge; 0 = reset.
REQ-005 stall  input  1  hazard unit request to hold PC and IF/ID contents.
REQ-006 flush  input  1  request to replace IF/ID contents with a bubble.
REQ-007 redirect  input  1  taken branch or jump; load PC from redirect_pc.
REQ-008 redirect_pc  input  32  branch or jump target.
REQ-009 imem_addr  output  32  byte address to the combinational instruction memory.
REQ-010 imem_rdata  input  32  instruction word at imem_addr, valid in the same cycle.
REQ-011 if_id_pc  output  32  PC of the instruction held in IF/ID.
REQ-012 if_id_pc4  output  32  if_id_pc + 4, modulo 2^32.
REQ-013 if_id_instr  output  32  instruction word held in IF/ID.
REQ-014 if_id_valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble.
REQ-015 misalign_err  output  1  one-cycle pulse on a misaligned redirect target.
REQ-016 fetch_count  output  32  number of real instructions delivered to IF/ID since reset.

Function
REQ-017 The block SHALL hold a 32-bit PC register and drive imem_addr = PC combinationally.
REQ-018 The block SHALL implement a two-state FSM, BOOT and RUN; reset enters BOOT, and BOOT goes to RUN unconditionally on the next edge.
REQ-019 In BOOT, the block SHALL hold PC at RESET_PC and load a bubble into IF/ID, so the first real instruction appears in IF/ID two edges after rst deasserts.
REQ-020 In RUN, next-PC priority SHALL be: redirect, then stall, then PC+4.
  - redirect: PC <= {redirect_pc[31:2],2'b00}.
  - stall: PC holds.
  - otherwise: PC <= PC+4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-021 In RUN, IF/ID update priority SHALL be: flush or redirect, then stall, then load.
  - flush or redirect: if_id_instr=NOP_INSTR, if_id_valid=0, if_id_pc=PC.
  - stall: IF/ID holds.
  - load: if_id_instr=imem_rdata, if_id_pc=PC, if_id_valid=1.
REQ-022 When redirect and stall are both 1, the redirect SHALL take effect and the stall SHALL be ignored for both PC and IF/ID.
REQ-023 When flush and stall are both 1 without redirect, PC SHALL hold and IF/ID SHALL take a bubble.
REQ-024 Fetch latency SHALL be one cycle, from PC to IF/ID, with no back-pressure beyond stall.
REQ-025 When redirect=1 and redirect_pc[1:0]!=0, misalign_err SHALL be 1 for exactly the following cycle; otherwise misalign_err SHALL be 0.
REQ-026 fetch_count SHALL increment by 1 on each edge that loads a real instruction (if_id_valid becomes or stays 1 by load, not by hold), wrapping modulo 2^32.
REQ-027 if_id_pc4 SHALL always equal if_id_pc+4 modulo 2^32, including for bubbles.
REQ-028 The block SHALL ignore stall, flush and redirect in BOOT.

Reset
REQ-029 rst=0 at an edge SHALL force: PC=RESET_PC, FSM=BOOT, if_id_instr=NOP_INSTR, if_id_valid=0, if_id_pc=RESET_PC, if_id_pc4=RESET_PC+4, misalign_err=0, fetch_count=0.
REQ-030 Reset SHALL override every other input, including mid-stall and mid-redirect, and SHALL take effect on the same edge.

Verification
REQ-031 Sequential fetch: reset, then 4 cycles with imem returning mem[PC>>2] -> if_id_pc = 0, 4, 8, 12 on successive cycles after BOOT; if_id_valid=1; fetch_count=4.
REQ-032 Stall: stall=1 for 2 cycles while IF/ID holds PC=8 -> IF/ID and imem_addr=12 unchanged; fetch_count unchanged; sequential fetch resumes at PC 12.
REQ-033 Redirect: redirect=1, redirect_pc=32'h40 with PC=16 -> next cycle imem_addr=32'h40 and if_id_valid=0; the cycle after, if_id_pc=32'h40 and if_id_valid=1.
REQ-034 Simultaneous events:
  - redirect=1, stall=1, redirect_pc=32'h80 -> PC=32'h80 and bubble in IF/ID.
  - flush=1, stall=1 -> PC held and bubble in IF/ID.
REQ-035 Misaligned target and wrap: redirect_pc=32'h102 -> PC=32'h100 and misalign_err high for one cycle; RESET_PC=32'hFFFF_FFFC -> second fetch at 32'h0 and if_id_pc4=32'h0 while if_id_pc=32'hFFFF_FFFC.
REQ-036 Reset mid-operation: rst=0 during stall with fetch_count=7 -> next edge PC=RESET_PC, fetch_count=0, if_id_valid=0, BOOT re-entered.
